// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared states, width codes and lane masks for the data RAM front end
package mem_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} mau_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_B    = 4'b0001;
    localparam logic [3:0] MASK_H    = 4'b0011;
    localparam logic [3:0] MASK_W    = 4'b1111;

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B, F3_BU: lane_mask = MASK_B << off;
            F3_H, F3_HU: lane_mask = MASK_H << off;
            F3_W:        lane_mask = MASK_W;
            default:     lane_mask = MASK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - lane select and sign/zero extension of a 32-bit RAM read word
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] mem_read_data,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    assign shifted = mem_read_data >> {off, 3'b000};

    always_comb begin
        result = shifted;
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   result = {24'h000000, shifted[7:0]};
            F3_HU:   result = {16'h0000, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/half/word load-store front end for the SPRAM data RAM
module mem_access_unit
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned SIZE_BYTES = 131072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    output logic        ready,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memWrite,
    output logic [3:0]  byteMask,
    input  logic [31:0] memReadData
);

    mau_state_t  state, state_nx;
    logic        accept;
    logic [32:0] diff;
    logic        misaligned, out_of_range, illegal, req_err;

    logic [31:0] mem_addr_q, wdata_sh_q, load_res;
    logic [3:0]  mask_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        we_q, err_q;

    assign accept = req && (state == IDLE);

    // 33-bit difference so an address below BASE_ADDR cannot wrap back into range
    assign diff         = {1'b0, addr} - {1'b0, BASE_ADDR};
    assign out_of_range = diff >= 33'(SIZE_BYTES);

    always_comb begin
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (funct3)
            F3_B:        illegal = 1'b0;
            F3_H:        misaligned = addr[0];
            F3_W:        misaligned = (addr[1:0] != 2'b00);
            F3_BU:       illegal = we;
            F3_HU: begin
                illegal    = we;
                misaligned = addr[0];
            end
            default:     illegal = 1'b1;
        endcase
    end

    assign req_err = misaligned || out_of_range || illegal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        ack      = 1'b0;
        err      = 1'b0;
        memWrite = 1'b0;
        byteMask = MASK_NONE;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (req) state_nx = req_err ? RESP : ACCESS;
            end
            ACCESS: begin
                byteMask = mask_q;
                memWrite = we_q;
                state_nx = we_q ? RESP : CAPTURE;
            end
            CAPTURE: state_nx = RESP;
            RESP: begin
                ack      = 1'b1;
                err      = err_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr_q <= 32'h0;
            wdata_sh_q <= 32'h0;
            mask_q     <= MASK_NONE;
            f3_q       <= F3_W;
            off_q      <= 2'b00;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            rdata      <= 32'h0;
        end else begin
            if (accept) begin
                mem_addr_q <= {2'b00, diff[31:2]};
                wdata_sh_q <= wdata << {addr[1:0], 3'b000};
                mask_q     <= lane_mask(funct3, addr[1:0]);
                f3_q       <= funct3;
                off_q      <= addr[1:0];
                we_q       <= we;
                err_q      <= req_err;
            end
            if (state == CAPTURE) rdata <= load_res;
        end
    end

    assign memAddress   = mem_addr_q;
    assign memWriteData = wdata_sh_q;

    load_align u_load_align (
        .mem_read_data (memReadData),
        .off           (off_q),
        .funct3        (f3_q),
        .result        (load_res)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit with a RAM model and scoreboard
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          SIZE = 131072;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, ready, we, ack, err, memWrite;
    logic [31:0] addr, wdata, rdata, memAddress, memWriteData, memReadData;
    logic [2:0]  funct3;
    logic [3:0]  byteMask;

    mem_access_unit #(.BASE_ADDR(BASE), .SIZE_BYTES(SIZE)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .ready        (ready),
        .addr         (addr),
        .we           (we),
        .funct3       (funct3),
        .wdata        (wdata),
        .rdata        (rdata),
        .ack          (ack),
        .err          (err),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .memWrite     (memWrite),
        .byteMask     (byteMask),
        .memReadData  (memReadData)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [0:SIZE/4-1];

    always @(posedge clk) begin
        if (memWrite) begin
            for (int i = 0; i < 4; i++)
                if (byteMask[i]) ram[memAddress[14:0]][8*i +: 8] <= memWriteData[8*i +: 8];
        end
        memReadData <= ram[memAddress[14:0]];
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_maddr;
        logic [31:0] exp_wd;
        logic [3:0]  exp_mask;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_rdata = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (ack === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack=1 expected no response at %0t", $time);
            end else begin
                e = sbq.pop_front();
                chk("ack_rdata", rdata, e.rdata);
                chk("ack_err", {31'b0, err}, {31'b0, e.err});
            end
        end
    end

    task automatic add(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee, input int lat,
                       input logic [31:0] ma, input logic [31:0] wd, input logic [3:0] m);
        vec_t v;
        v = '{w, f, a, d, er, ee, lat, ma, wd, m};
        vecs.push_back(v);
    endtask

    task automatic issue(input vec_t v, input int idx);
        int   cyc;
        logic got, wrote;
        if (!v.we && !v.exp_err) model_rdata = v.exp_rdata;
        sbq.push_back('{model_rdata, v.exp_err});
        @(negedge clk);
        req = 1'b1; we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
        @(posedge clk);
        #1 req = 1'b0;
        cyc = 0; got = 1'b0; wrote = 1'b0;
        while (!got && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (memWrite) wrote = 1'b1;
            if (cyc == 1 && !v.exp_err) begin
                chk($sformatf("v%0d_maddr", idx), memAddress, v.exp_maddr);
                chk($sformatf("v%0d_mask", idx), {28'b0, byteMask}, {28'b0, v.exp_mask});
                chk($sformatf("v%0d_memwrite", idx), {31'b0, memWrite}, {31'b0, v.we});
                if (v.we) chk($sformatf("v%0d_wdata", idx), memWriteData, v.exp_wd);
            end
            if (ack) got = 1'b1;
        end
        chk($sformatf("v%0d_latency", idx), 32'(cyc), 32'(v.exp_lat));
        if (v.exp_err) chk($sformatf("v%0d_no_write", idx), {31'b0, wrote}, 32'h0);
    endtask

    logic [31:0] b2b_addr [4];
    logic [31:0] b2b_exp  [4];

    initial begin
        int n, cyc, last;
        for (int i = 0; i < SIZE/4; i++) ram[i] = 32'h0;
        reset = 1'b0; req = 1'b0; we = 1'b0; funct3 = F3_W; addr = 32'h0; wdata = 32'h0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'h1);
        chk("rst_ack", {31'b0, ack}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_memwrite", {31'b0, memWrite}, 32'h0);
        chk("rst_mask", {28'b0, byteMask}, 32'h0);
        chk("rst_maddr", memAddress, 32'h0);
        chk("rst_wd", memWriteData, 32'h0);
        reset = 1'b1;

        //  we    f3     addr          wdata         exp_rdata     err lat maddr        wd            mask
        add(1'b1, F3_W,  32'h10,       32'hDEADBEEF, 32'h0,        0,  2,  32'h4,       32'hDEADBEEF, 4'b1111);
        add(1'b0, F3_W,  32'h10,       32'h0,        32'hDEADBEEF, 0,  3,  32'h4,       32'h0,        4'b1111);
        add(1'b1, F3_B,  32'h13,       32'h000000A5, 32'h0,        0,  2,  32'h4,       32'hA5000000, 4'b1000);
        add(1'b0, F3_B,  32'h13,       32'h0,        32'hFFFFFFA5, 0,  3,  32'h4,       32'h0,        4'b1000);
        add(1'b0, F3_BU, 32'h13,       32'h0,        32'h000000A5, 0,  3,  32'h4,       32'h0,        4'b1000);
        add(1'b0, F3_B,  32'h11,       32'h0,        32'hFFFFFFBE, 0,  3,  32'h4,       32'h0,        4'b0010);
        add(1'b0, F3_HU, 32'h10,       32'h0,        32'h0000BEEF, 0,  3,  32'h4,       32'h0,        4'b0011);
        add(1'b1, F3_H,  32'h22,       32'h00008001, 32'h0,        0,  2,  32'h8,       32'h80010000, 4'b1100);
        add(1'b0, F3_H,  32'h22,       32'h0,        32'hFFFF8001, 0,  3,  32'h8,       32'h0,        4'b1100);
        add(1'b0, F3_HU, 32'h22,       32'h0,        32'h00008001, 0,  3,  32'h8,       32'h0,        4'b1100);
        add(1'b1, F3_W,  32'h0001FFFC, 32'h12345678, 32'h0,        0,  2,  32'h00007FFF, 32'h12345678, 4'b1111);
        add(1'b0, F3_W,  32'h0001FFFC, 32'h0,        32'h12345678, 0,  3,  32'h00007FFF, 32'h0,        4'b1111);
        add(1'b0, F3_W,  32'h02,       32'h0,        32'h0,        1,  1,  32'h0,       32'h0,        4'b0000);
        add(1'b1, F3_H,  32'h01,       32'h1234,     32'h0,        1,  1,  32'h0,       32'h0,        4'b0000);
        add(1'b0, F3_W,  32'h00020000, 32'h0,        32'h0,        1,  1,  32'h0,       32'h0,        4'b0000);
        add(1'b0, 3'b011, 32'h0,       32'h0,        32'h0,        1,  1,  32'h0,       32'h0,        4'b0000);
        add(1'b1, F3_BU, 32'h0,        32'h55,       32'h0,        1,  1,  32'h0,       32'h0,        4'b0000);

        foreach (vecs[i]) issue(vecs[i], i);

        // reset while a store sits in ACCESS: the write must not land
        @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = F3_W; addr = 32'h40; wdata = 32'h11111111;
        @(posedge clk);
        #1 req = 1'b0;
        chk("rst_mid_memwrite_before", {31'b0, memWrite}, 32'h1);
        #1 reset = 1'b0;
        #1;
        chk("rst_mid_memwrite_after", {31'b0, memWrite}, 32'h0);
        chk("rst_mid_ready", {31'b0, ready}, 32'h1);
        chk("rst_mid_ack", {31'b0, ack}, 32'h0);
        chk("rst_mid_rdata", rdata, 32'h0);
        model_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_ready_after_release", {31'b0, ready}, 32'h1);
        issue('{1'b0, F3_W, 32'h40, 32'h0, 32'h0, 1'b0, 3, 32'h10, 32'h0, 4'b1111}, 100);
        issue('{1'b0, F3_W, 32'h10, 32'h0, 32'hA5ADBEEF, 1'b0, 3, 32'h4, 32'h0, 4'b1111}, 101);

        // back-to-back loads with req held high
        b2b_addr[0] = 32'h10; b2b_exp[0] = 32'hA5ADBEEF;
        b2b_addr[1] = 32'h14; b2b_exp[1] = 32'h00000000;
        b2b_addr[2] = 32'h20; b2b_exp[2] = 32'h80010000;
        b2b_addr[3] = 32'h0001FFFC; b2b_exp[3] = 32'h12345678;
        for (int i = 0; i < 4; i++) sbq.push_back('{b2b_exp[i], 1'b0});
        model_rdata = b2b_exp[3];
        @(negedge clk);
        req = 1'b1; we = 1'b0; funct3 = F3_W; addr = b2b_addr[0];
        n = 0; cyc = 0; last = 0;
        while (n < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ack) begin
                if (n == 0) chk("b2b_first_latency", 32'(cyc), 32'd3);
                else chk($sformatf("b2b_spacing%0d", n), 32'(cyc - last), 32'd4);
                last = cyc;
                n++;
                if (n < 4) addr = b2b_addr[n];
                else req = 1'b0;
            end
        end
        chk("b2b_ack_count", 32'(n), 32'd4);
        req = 1'b0;
        repeat (6) @(negedge clk);
        chk("b2b_queue_empty", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end that sits directly upstream of the SPRAM-backed 32-bit data RAM. It accepts one byte/half/word request at a time from the multicycle core, checks alignment and range, and turns the request into a word address, lane-shifted write data and a byte mask. It waits out the RAM's registered read latency, then returns a sign- or zero-extended load result with a single-cycle `ack`.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000: byte address of RAM word 0.
- `SIZE_BYTES`, 131072: RAM span in bytes; a power of two, at least 4.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low.
- `req`  in  1: request strobe. Sampled only when `ready`=1.
- `ready`  out  1: 1 in IDLE.
- `addr`  in  32: byte address.
- `we`  in  1: 1 = store, 0 = load.
- `funct3`  in  3: RV32I width code. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `wdata`  in  32: store data, right-aligned.
- `rdata`  out  32: registered load result.
- `ack`  out  1: one-cycle completion pulse.
- `err`  out  1: valid with `ack`. Set on misaligned, out-of-range or illegal-`funct3` requests.
- `memAddress`  out  32: word index, `(addr-BASE_ADDR)>>2`.
- `memWriteData`  out  32: lane-shifted store data.
- `memWrite`  out  1: RAM write enable.
- `byteMask`  out  4: bit i enables lane i (bits 8i+7:8i).
- `memReadData`  in  32: RAM data. Valid the cycle after the address is presented.

## Operation
Request capture:
- On `req && ready`, register `addr`, `we`, `funct3`, `wdata` and the offset `off = addr[1:0]`.

Error checks:
- Misaligned: H/HU with `off[0]`=1, or W with `off`≠0.
- Out of range: `addr < BASE_ADDR` or `addr-BASE_ADDR >= SIZE_BYTES`.
- Illegal width: `funct3` ∈ {011, 110, 111}; stores with 100/101 are also illegal.
- Any error sends the FSM to RESP with `err`=1. No RAM access occurs and `memWrite` stays 0.

Stores:
- `memWriteData = wdata << (8*off)`.
- `byteMask` = 0001<<off for B, 0011<<off for H, 1111 for W.

Loads:
- Select lane(s) `memReadData >> (8*off)`.
- B/H sign-extend, BU/HU zero-extend, W passes through.

FSM states:
- IDLE: `ready`=1. Accepted request → ACCESS if legal, else RESP.
- ACCESS: drive `memAddress` and `byteMask`. `memWrite`=`we`, held for this cycle only. Store → RESP; load → CAPTURE.
- CAPTURE: register the extracted load into `rdata` → RESP.
- RESP: `ack`=1, `err` as computed → IDLE.

Output behaviour:
- `memAddress`, `memWriteData` and `byteMask` are driven from the captured registers in every state.
- Outside ACCESS, `byteMask`=0000 and `memWrite`=0.
- `rdata` holds its last value until the next load completes. Store and error responses leave it unchanged.

## Timing
- Reset values: state IDLE, `ready`=1, `ack`=0, `err`=0, `rdata`=0, `memWrite`=0, `byteMask`=0, `memAddress`=0, `memWriteData`=0.
- Accept at edge T. Store: `memWrite` high in T+1, `ack` in T+2. Load: address in T+1, data sampled at end of T+2, `ack` and `rdata` in T+3. Error: `ack`+`err` in T+1.
- Throughput: a new request can be accepted in the cycle after RESP. `ready` is low from ACCESS through RESP, and `req` is ignored then.
- Back-to-back requests: `req` held high across `ack` is accepted again in the first IDLE cycle. There is no request buffering.
- Reset asserted mid-operation: FSM returns to IDLE immediately (asynchronous) and `memWrite` drops in the same instant. A partially issued store is not retried.
- Last word (`addr = BASE_ADDR+SIZE_BYTES-4`) is legal. `addr = BASE_ADDR+SIZE_BYTES` is out of range. Computing the offset must not wrap into range: compare with a 33-bit difference.

## Structure
- Shared package `mem_pkg`:
  - `typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP}`.
  - `funct3` width constants F3_B/H/W/BU/HU.
  - Lane-mask constants.
- One sub-module, `load_align`: combinational lane select and sign/zero extend (`memReadData`, `off`, `funct3` → 32-bit result). It is reused by any future I/O bus bridge.
- Store shifting, mask generation, error checking and the FSM live in `mem_access_unit`.

## Test plan
- Store word then load word: SW addr 0x10, data 0xDEADBEEF → ACCESS with `memAddress`=4, `byteMask`=1111, `ack` at T+2. LW 0x10 → `rdata`=0xDEADBEEF at T+3.
- Byte store and signed/unsigned loads: SB 0x13 data 0x000000A5 → `memWriteData`=0xA5000000, `byteMask`=1000. LB 0x13 → 0xFFFFFFA5; LBU 0x13 → 0x000000A5.
- Halfword at offset 2: SH 0x22 data 0x8001 → `byteMask`=1100. LH → 0xFFFF8001; LHU → 0x00008001.
- Errors, each giving `ack`+`err` at T+1, `memWrite` never high, `rdata` unchanged:
  - LW 0x02 (misaligned).
  - SH 0x01 (misaligned).
  - LW `BASE_ADDR+SIZE_BYTES` (out of range).
  - `funct3`=011 (illegal).
- Reset in ACCESS during SW: `memWrite` falls asynchronously, `ready`=1 after release, no `ack`. A following LW returns correct data.
- Back-to-back with `req` held high: 4 LW accepted every 4 cycles, exactly one `ack` per request.
